// File: rtl/rx_pbm.sv
// rx_pbm: receive packet buffer manager.
// Payload beats from the parser are written into a circular word RAM.
// Each packet's word count goes into a small length FIFO. A packet is
// committed only if it ended cleanly; an errored or overflowing packet is
// rolled back. Committed packets are replayed on an AXI-Stream master.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   s_pbm_wdata/wvalid/wlast/werror  parser write beats
//   o_pbm_ready              write ready (never stalls after reset)
//   m_axis_tdata/tvalid/tlast/tready  replayed payload stream
//   o_free_words             RAM words not held by committed packets
//   o_pkt_count              committed packets not yet fully read
//   o_drop_cnt, o_drop_pulse dropped-packet counter and per-drop pulse
module rx_pbm #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int PKT_AW     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_pbm_wdata,
    input  logic                  s_pbm_wvalid,
    input  logic                  s_pbm_wlast,
    input  logic                  s_pbm_werror,
    output logic                  o_pbm_ready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [ADDR_WIDTH:0]   o_free_words,
    output logic [PKT_AW:0]       o_pkt_count,
    output logic [15:0]           o_drop_cnt,
    output logic                  o_drop_pulse
);

    localparam int DEPTH    = 1 << ADDR_WIDTH;
    localparam int LF_DEPTH = 1 << PKT_AW;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PKT_AW:0]     LF_ONE  = 1;
    localparam logic [PKT_AW:0]     LF_FULL = {1'b1, {PKT_AW{1'b0}}};
    localparam logic [15:0]         SAT     = 16'hFFFF;

    typedef enum logic {W_ACCEPT, W_DISCARD} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_LOAD, R_STREAM} rstate_t;

    logic [DATA_WIDTH-1:0] mem    [DEPTH];
    logic [15:0]           lf_mem [LF_DEPTH];

    logic [ADDR_WIDTH:0] wr_commit, wr_tent, rd_ptr, rd_ptr_inc, tent_used;
    logic [PKT_AW:0]     lf_wr, lf_rd;
    logic [15:0]         beat_cnt, rd_rem;
    logic                err, ovf;
    wstate_t             wr_state, wr_next;
    rstate_t             rd_state, rd_next;

    logic accept, has_space, ram_we, pkt_end, pkt_ok, pkt_drop;
    logic lf_empty, fire, last_fire, lf_pop, ram_re;
    logic [ADDR_WIDTH-1:0] ram_raddr;

    assign accept     = s_pbm_wvalid && o_pbm_ready;
    assign tent_used  = wr_tent - rd_ptr;
    assign has_space  = tent_used < DEPTH_W;
    assign rd_ptr_inc = rd_ptr + PTR_ONE;
    assign lf_empty   = (lf_wr == lf_rd);

    // ---- write side: state register ----
    always_ff @(posedge clk) begin
        if (rst) wr_state <= W_ACCEPT;
        else     wr_state <= wr_next;
    end

    // ---- write side: next state ----
    always_comb begin
        wr_next = wr_state;
        if (pkt_end)
            wr_next = W_ACCEPT;
        else if (accept && wr_state == W_ACCEPT && !has_space)
            wr_next = W_DISCARD;
    end

    // ---- write side: decoded strobes ----
    // Commit capacity counts the packet being streamed as well, so at most
    // LF_DEPTH packets are ever committed and the length FIFO cannot overrun.
    always_comb begin
        ram_we   = accept && (wr_state == W_ACCEPT) && has_space;
        pkt_end  = accept && s_pbm_wlast;
        pkt_ok   = pkt_end && ram_we && !err && !ovf && !s_pbm_werror &&
                   (o_pkt_count != LF_FULL);
        pkt_drop = pkt_end && !pkt_ok;
    end

    // ---- write side: pointers, flags, drop accounting ----
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_tent      <= '0;
            wr_commit    <= '0;
            beat_cnt     <= '0;
            err          <= 1'b0;
            ovf          <= 1'b0;
            lf_wr        <= '0;
            o_pbm_ready  <= 1'b0;
            o_drop_cnt   <= '0;
            o_drop_pulse <= 1'b0;
        end else begin
            o_pbm_ready  <= 1'b1;
            o_drop_pulse <= pkt_drop;
            if (pkt_drop && o_drop_cnt != SAT)
                o_drop_cnt <= o_drop_cnt + 16'd1;
            if (pkt_end) begin
                err      <= 1'b0;
                ovf      <= 1'b0;
                beat_cnt <= '0;
                if (pkt_ok) begin
                    wr_tent   <= wr_tent + PTR_ONE;
                    wr_commit <= wr_tent + PTR_ONE;
                    lf_wr     <= lf_wr + LF_ONE;
                end else begin
                    wr_tent <= wr_commit;
                end
            end else if (accept) begin
                err <= err | s_pbm_werror;
                if (ram_we) begin
                    wr_tent  <= wr_tent + PTR_ONE;
                    beat_cnt <= beat_cnt + 16'd1;
                end else if (wr_state == W_ACCEPT) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    // ---- storage writes (data only, no reset) ----
    always_ff @(posedge clk) begin
        if (ram_we)
            mem[wr_tent[ADDR_WIDTH-1:0]] <= s_pbm_wdata;
        if (pkt_ok)
            lf_mem[lf_wr[PKT_AW-1:0]] <= beat_cnt + 16'd1;
    end

    // ---- read side: state register ----
    always_ff @(posedge clk) begin
        if (rst) rd_state <= R_IDLE;
        else     rd_state <= rd_next;
    end

    // ---- read side: next state ----
    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:   if (!lf_empty) rd_next = R_LOAD;
            R_LOAD:   rd_next = R_STREAM;
            R_STREAM: if (last_fire) rd_next = lf_empty ? R_IDLE : R_LOAD;
            default:  rd_next = R_IDLE;
        endcase
    end

    // ---- read side: decoded strobes ----
    // On each handshake the next word is fetched into the output register at
    // the same edge, which gives back-to-back words while tready stays high.
    always_comb begin
        fire      = m_axis_tvalid && m_axis_tready;
        last_fire = fire && (rd_rem == 16'd1);
        lf_pop    = !lf_empty && ((rd_state == R_IDLE) || last_fire);
        ram_re    = (rd_state == R_LOAD) || (fire && (rd_rem != 16'd1));
        ram_raddr = (rd_state == R_LOAD) ? rd_ptr[ADDR_WIDTH-1:0]
                                         : rd_ptr_inc[ADDR_WIDTH-1:0];
    end

    // ---- read side: pointer, remaining count, output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr        <= '0;
            lf_rd         <= '0;
            rd_rem        <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else begin
            if (lf_pop) begin
                lf_rd  <= lf_rd + LF_ONE;
                rd_rem <= lf_mem[lf_rd[PKT_AW-1:0]];
            end else if (fire) begin
                rd_rem <= rd_rem - 16'd1;
            end
            if (fire)
                rd_ptr <= rd_ptr_inc;
            if (ram_re)
                m_axis_tdata <= mem[ram_raddr];
            if (rd_state == R_LOAD) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= (rd_rem == 16'd1);
            end else if (fire) begin
                m_axis_tvalid <= !last_fire;
                m_axis_tlast  <= (rd_rem == 16'd2);
            end
        end
    end

    // ---- status counters ----
    always_ff @(posedge clk) begin
        if (rst) begin
            o_pkt_count  <= '0;
            o_free_words <= DEPTH_W;
        end else begin
            o_free_words <= DEPTH_W - (wr_commit - rd_ptr);
            if (pkt_ok && !last_fire)
                o_pkt_count <= o_pkt_count + LF_ONE;
            else if (!pkt_ok && last_fire)
                o_pkt_count <= o_pkt_count - LF_ONE;
        end
    end

endmodule

// File: doc/rx_pbm.md
# rx_pbm

Receive packet buffer manager between the UDP receive parser and the downstream payload consumer. Stores payload beats from the parser's PBM write interface in a circular word RAM and tracks each packet's word count in a length FIFO. A packet is committed only if it ended cleanly; an errored or overflowing packet is rolled back. Committed packets are replayed as an AXI-Stream with correct `tlast`.

## Interface
- DATA_WIDTH, 32, payload word width
- ADDR_WIDTH, 10, payload RAM address bits; DEPTH = 2^ADDR_WIDTH words
- PKT_AW, 4, length FIFO address bits; up to 2^PKT_AW committed packets

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- s_pbm_wdata  in  DATA_WIDTH  payload beat from parser
- s_pbm_wvalid  in  1  beat valid
- s_pbm_wlast  in  1  last payload beat of packet
- s_pbm_werror  in  1  frame error flag; may assert on any beat
- o_pbm_ready  out  1  write ready to parser
- m_axis_tdata  out  DATA_WIDTH  replayed payload
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  last word of packet
- m_axis_tready  in  1  downstream ready
- o_free_words  out  ADDR_WIDTH+1  uncommitted-free RAM words
- o_pkt_count  out  PKT_AW+1  committed packets not yet fully read
- o_drop_cnt  out  16  dropped packets, saturating
- o_drop_pulse  out  1  one-cycle pulse per dropped packet

## Operation
- Write accepted on a cycle with `s_pbm_wvalid && o_pbm_ready`.
- `o_pbm_ready` is registered: 0 in reset, 1 from the first cycle after `rst` deasserts. It never stalls the parser; overflow is handled by tail drop.
- Pointers are ADDR_WIDTH+1 bits with a wrap bit: `wr_commit`, `wr_tent`, `rd_ptr`. Full when the pointers differ only in MSB.
- Write FSM states are ACCEPT and DISCARD.
  - **ACCEPT:** on a beat, if `wr_tent - rd_ptr < DEPTH`, write the RAM at `wr_tent[ADDR_WIDTH-1:0]` and increment `wr_tent` and the 16-bit `beat_cnt`. Otherwise set sticky `ovf` and go to DISCARD.
  - `s_pbm_werror` on any accepted beat sets sticky `err`.
  - **DISCARD:** beats are accepted and not written, until `wlast`.
- Packet end is an accepted beat with `s_pbm_wlast`, in either state.
  - **Commit:** if `!err && !ovf && !s_pbm_werror` and the length FIFO is not full, push the final `beat_cnt` (including the last beat) and set `wr_commit <= wr_tent` (+1 for the last beat).
  - **Drop:** otherwise set `wr_tent <= wr_commit`, pulse `o_drop_pulse`, and increment `o_drop_cnt`, saturating at 16'hFFFF.
  - **Clear:** in both cases clear `err`, `ovf` and `beat_cnt`, and return to ACCEPT.
- Read FSM states are IDLE, LOAD and STREAM.
  - **IDLE:** when the length FIFO is non-empty, pop the length into `rd_rem` and go to LOAD.
  - **LOAD:** issue the synchronous RAM read at `rd_ptr`.
  - **STREAM:** present the registered data with prefetch so there are no bubbles while `tready` is high. `m_axis_tlast = (rd_rem == 1)`.
  - On each `tvalid && tready`: increment `rd_ptr` and decrement `rd_rem`. The last word returns to IDLE, or goes directly to LOAD if another packet is committed.
- `o_free_words = DEPTH - (wr_commit - rd_ptr)`.
- `o_pkt_count` = FIFO entries plus 1 while a packet is streaming.
- A commit and a read completion in the same cycle leave `o_pkt_count` unchanged.
- Space freed by reads is visible to the write side one cycle later (registered `rd_ptr`), which is conservative.
- A single-beat packet (`wlast` on the first beat) is a legal 1-word packet.
- `beat_cnt` that would exceed DEPTH is impossible without `ovf`, so 16 bits is sufficient.

## Timing
- All outputs are registered.
- Reset values:
  - `o_pbm_ready` = 0, `m_axis_tvalid` = 0, `m_axis_tlast` = 0, `m_axis_tdata` = 0
  - `o_free_words` = DEPTH, `o_pkt_count` = 0, `o_drop_cnt` = 0, `o_drop_pulse` = 0
  - all pointers 0, FSMs in ACCEPT and IDLE
- Commit latency: the first `m_axis_tvalid` is no later than 3 cycles after the clock edge accepting the committing `wlast` beat, given an idle read side.
- Within a packet, with `tready` held high, one word per cycle.
- Holding `tready` low keeps `tdata`/`tlast` stable with `tvalid` high.
- `o_drop_pulse` is high in the cycle after the dropping `wlast` beat.
- Reset mid-packet or mid-stream discards all content immediately. Output returns to reset values on the next edge.

## Test plan
1. **Clean packets:** three clean packets of 4, 1 and 7 words, `tready`=1 → output 12 words in order; `tlast` on words 4, 5 and 12; `o_drop_cnt`=0; `o_free_words` returns to 1024.
2. **Errored packet:** a 5-word packet with `werror` on beat 3, then a clean 2-word packet → only the 2 words are output; `o_drop_cnt`=1; the drop pulse comes after beat 5.
3. **RAM overflow:** ADDR_WIDTH=4, `tready`=0, packet A of 10 words, then packet B of 10 words → A commits, B is dropped (`ovf`) with `o_free_words`=6 held; releasing `tready` outputs only A.
4. **Length FIFO full:** PKT_AW=2, `tready`=0, five 1-word packets → four commit, the fifth is dropped; `o_pkt_count`=4.
5. **Wrap and backpressure:** ADDR_WIDTH=4, stream 40 random-length clean packets with random `tready` → scoreboard exact match, `tvalid` stable under stall, pointer wrap is exercised.
6. **Reset mid-operation:** assert `rst` mid-write and mid-read → all outputs at reset values the next cycle; a subsequent 3-word packet outputs correctly.
